// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_pkg
// Description : Shared UART constants and types. Holds the oversample
//               default, the minimum legal integer divisor and the divisor
//               struct used by the baud generator and its users.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default number of os_ticks per UART bit.
    localparam int DEF_OVERSAMPLE = 16;

    // Smallest integer divisor that still yields a sensible interval.
    localparam int MIN_DIV_INT = 2;

    // Default divisor widths, matching the generator's default parameters.
    localparam int BAUD_DIV_W  = 16;
    localparam int BAUD_FRAC_W = 4;

    // Divisor pair: integer clocks per os_tick plus a fractional remainder
    // in 1/2^BAUD_FRAC_W clock units.
    typedef struct packed {
        logic [BAUD_DIV_W-1:0]  int_val;
        logic [BAUD_FRAC_W-1:0] frac_val;
    } baud_div_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/baud_frac_acc.sv
`default_nettype none
// ============================================================================
// Module      : baud_frac_acc
// Description : Combinational interval-length logic for the fractional baud
//               generator. Adds the fractional divisor to the accumulator; a
//               carry lengthens the current interval by one clock.
// Ports       : i_cnt       - current interval counter
//               i_acc       - fractional accumulator
//               i_act_int   - active integer divisor (>= 2)
//               i_act_frac  - active fractional divisor
//               o_last      - current cycle is the last of the interval
//               o_acc_next  - accumulator value for the next interval
// Revision    : 1.0 - initial release
// ============================================================================
module baud_frac_acc #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic [DIV_W:0]    i_cnt,
    input  logic [FRAC_W-1:0] i_acc,
    input  logic [DIV_W-1:0]  i_act_int,
    input  logic [FRAC_W-1:0] i_act_frac,
    output logic              o_last,
    output logic [FRAC_W-1:0] o_acc_next
);

    logic [FRAC_W:0] w_sum;
    logic [DIV_W:0]  w_len_m1;

    assign w_sum = {1'b0, i_acc} + {1'b0, i_act_frac};

    // len - 1 computed one bit wider than the divisor so that a full-scale
    // divisor plus carry (len = 2^DIV_W) cannot wrap.
    assign w_len_m1 = {1'b0, i_act_int} - (DIV_W+1)'(1)
                    + {{DIV_W{1'b0}}, w_sum[FRAC_W]};

    assign o_last     = (i_cnt == w_len_m1);
    assign o_acc_next = w_sum[FRAC_W-1:0];

endmodule : baud_frac_acc
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Programmable fractional baud-rate generator. Issues a
//               one-cycle os_tick every act_int + act_frac/2^FRAC_W clocks
//               on average, plus mid_tick/bit_tick derived from a phase
//               counter. Divisor reloads are deferred to the interval
//               boundary so the tick train never glitches.
// Ports       : clk, reset (async, active-high)
//               en          - count enable, freezes all state when low
//               resync      - restart interval, phase and accumulator
//               div_int/div_frac/div_load - divisor load request
//               div_pending - valid load waiting for interval end
//               div_err     - sticky: last rejected load (cleared by valid)
//               os_tick/mid_tick/bit_tick - registered one-cycle pulses
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DEF_INT    = 4,
    parameter int DEF_FRAC   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              resync,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              div_pending,
    output logic              div_err,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick
);

    localparam int c_PH_W = $clog2(OVERSAMPLE);
    localparam logic [c_PH_W-1:0] c_MID_PRE  = c_PH_W'(OVERSAMPLE/2 - 1);
    localparam logic [c_PH_W-1:0] c_LAST_PH  = c_PH_W'(OVERSAMPLE - 1);

    generate
        if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
            $error("uart_baud_gen: OVERSAMPLE must be a power of two >= 4");
        end
        if (DEF_INT < MIN_DIV_INT) begin : g_bad_def_int
            $error("uart_baud_gen: DEF_INT must be at least MIN_DIV_INT");
        end
    endgenerate

    logic [DIV_W-1:0]  r_act_int;
    logic [FRAC_W-1:0] r_act_frac;
    logic [DIV_W-1:0]  r_sh_int;
    logic [FRAC_W-1:0] r_sh_frac;
    logic              r_pending;
    logic              r_err;
    logic [DIV_W:0]    r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic [c_PH_W-1:0] r_ph;
    logic              r_os;
    logic              r_mid;
    logic              r_bit;

    logic              w_last;
    logic [FRAC_W-1:0] w_acc_next;
    logic              w_load_ok;
    logic              w_load_bad;
    logic              w_boundary;

    baud_frac_acc #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .i_cnt      (r_cnt),
        .i_acc      (r_acc),
        .i_act_int  (r_act_int),
        .i_act_frac (r_act_frac),
        .o_last     (w_last),
        .o_acc_next (w_acc_next)
    );

    assign w_load_ok  = div_load && (div_int >= DIV_W'(MIN_DIV_INT));
    assign w_load_bad = div_load && (div_int <  DIV_W'(MIN_DIV_INT));

    // Points where the active divisor may change: while frozen, on a
    // restart, or at the end of the running interval.
    assign w_boundary = !en || resync || w_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_act_int  <= DIV_W'(DEF_INT);
            r_act_frac <= FRAC_W'(DEF_FRAC);
            r_sh_int   <= DIV_W'(DEF_INT);
            r_sh_frac  <= FRAC_W'(DEF_FRAC);
            r_pending  <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_ph       <= '0;
            r_os       <= 1'b0;
            r_mid      <= 1'b0;
            r_bit      <= 1'b0;
        end else begin
            if (w_load_bad) begin
                r_err <= 1'b1;
            end else if (w_load_ok) begin
                r_err <= 1'b0;
            end

            // The shadow always tracks the latest valid request, so a
            // pending value can never be older than the active one.
            if (w_load_ok) begin
                r_sh_int  <= div_int;
                r_sh_frac <= div_frac;
            end

            if (w_boundary) begin
                if (w_load_ok) begin
                    r_act_int  <= div_int;
                    r_act_frac <= div_frac;
                end else if (r_pending && en) begin
                    r_act_int  <= r_sh_int;
                    r_act_frac <= r_sh_frac;
                end
            end

            if (!en) begin
                r_os  <= 1'b0;
                r_mid <= 1'b0;
                r_bit <= 1'b0;
            end else if (resync) begin
                // Restart beats a coinciding interval end: no tick issued.
                r_cnt     <= '0;
                r_acc     <= '0;
                r_ph      <= '0;
                r_pending <= 1'b0;
                r_os      <= 1'b0;
                r_mid     <= 1'b0;
                r_bit     <= 1'b0;
            end else if (w_last) begin
                r_cnt     <= '0;
                r_acc     <= w_acc_next;
                r_ph      <= r_ph + c_PH_W'(1);
                r_pending <= 1'b0;
                r_os      <= 1'b1;
                r_mid     <= (r_ph == c_MID_PRE);
                r_bit     <= (r_ph == c_LAST_PH);
            end else begin
                r_cnt <= r_cnt + (DIV_W+1)'(1);
                r_os  <= 1'b0;
                r_mid <= 1'b0;
                r_bit <= 1'b0;
                if (w_load_ok) begin
                    r_pending <= 1'b1;
                end
            end
        end
    end

    assign div_pending = r_pending;
    assign div_err     = r_err;
    assign os_tick     = r_os;
    assign mid_tick    = r_mid;
    assign bit_tick    = r_bit;

endmodule : uart_baud_gen
`default_nettype wire

// File: tb/tb_uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_baud_gen
// Description : Self-checking bench for uart_baud_gen. A behavioural model
//               tracks elapsed clocks, the fractional remainder and a tick
//               count as plain integers; the DUT is compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_baud_gen;
    import uart_pkg::*;

    localparam int c_OS   = 16;
    localparam int c_FDIV = 16;   // 2^FRAC_W

    logic        clk;
    logic        reset;
    logic        en;
    logic        resync;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        div_pending;
    logic        div_err;
    logic        os_tick;
    logic        mid_tick;
    logic        bit_tick;

    uart_baud_gen #(
        .DIV_W      (16),
        .FRAC_W     (4),
        .OVERSAMPLE (c_OS),
        .DEF_INT    (4),
        .DEF_FRAC   (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .resync      (resync),
        .div_int     (div_int),
        .div_frac    (div_frac),
        .div_load    (div_load),
        .div_pending (div_pending),
        .div_err     (div_err),
        .os_tick     (os_tick),
        .mid_tick    (mid_tick),
        .bit_tick    (bit_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    baud_div_t m_act;
    baud_div_t m_sh;
    int        m_elapsed;
    int        m_rem;
    int        m_phase;
    bit        m_pend;
    bit        m_err;
    bit        e_os, e_mid, e_bit;

    int n_os, n_mid, n_bit;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act     = '{int_val: 16'd4, frac_val: 4'd0};
        m_sh      = m_act;
        m_elapsed = 0;
        m_rem     = 0;
        m_phase   = 0;
        m_pend    = 0;
        m_err     = 0;
        e_os      = 0;
        e_mid     = 0;
        e_bit     = 0;
    endtask

    // One clock of the specification's behaviour, in integer terms.
    task automatic model_step(input bit e, input bit r, input bit l,
                              input int di, input int df);
        bit ok, bad, ends;
        int len;
        ok   = l && (di >= MIN_DIV_INT);
        bad  = l && (di <  MIN_DIV_INT);
        len  = int'(m_act.int_val) + (m_rem + int'(m_act.frac_val)) / c_FDIV;
        ends = (m_elapsed == len - 1);
        e_os = 0; e_mid = 0; e_bit = 0;
        if (bad) m_err = 1;
        else if (ok) m_err = 0;
        if (!e) begin
            if (ok) begin
                m_act = '{int_val: 16'(di), frac_val: 4'(df)};
                m_sh  = m_act;
            end
        end else if (r || ends) begin
            if (r) begin
                m_elapsed = 0;
                m_rem     = 0;
                m_phase   = 0;
            end else begin
                m_elapsed = 0;
                m_rem     = (m_rem + int'(m_act.frac_val)) % c_FDIV;
                m_phase   = (m_phase + 1) % c_OS;
                e_os      = 1;
                e_mid     = (m_phase == c_OS / 2);
                e_bit     = (m_phase == 0);
            end
            if (ok) begin
                m_act = '{int_val: 16'(di), frac_val: 4'(df)};
                m_sh  = m_act;
            end else if (m_pend) begin
                m_act = m_sh;
            end
            m_pend = 0;
        end else begin
            m_elapsed++;
            if (ok) begin
                m_sh   = '{int_val: 16'(di), frac_val: 4'(df)};
                m_pend = 1;
            end
        end
    endtask

    task automatic cycle(input bit e, input bit r, input bit l, input int di, input int df);
        en       = e;
        resync   = r;
        div_load = l;
        div_int  = 16'(di);
        div_frac = 4'(df);
        model_step(e, r, l, di, df);
        @(posedge clk);
        #1;
        check("os_tick",     os_tick,     e_os);
        check("mid_tick",    mid_tick,    e_mid);
        check("bit_tick",    bit_tick,    e_bit);
        check("div_pending", div_pending, m_pend);
        check("div_err",     div_err,     m_err);
        n_os  += int'(os_tick);
        n_mid += int'(mid_tick);
        n_bit += int'(bit_tick);
        resync   = 0;
        div_load = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0);
    endtask

    task automatic clear_counts();
        n_os = 0; n_mid = 0; n_bit = 0;
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_os"},   os_tick,     0);
        check({tag, "_mid"},  mid_tick,    0);
        check({tag, "_bit"},  bit_tick,    0);
        check({tag, "_pend"}, div_pending, 0);
        check({tag, "_err"},  div_err,     0);
    endtask

    initial begin
        reset = 1; en = 0; resync = 0; div_load = 0; div_int = 0; div_frac = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_low("reset");
        reset = 0;

        // Default divisor: 16 ticks, one mid and one bit per 64 cycles.
        clear_counts();
        run(64);
        check("def_os_cnt",  n_os,  16);
        check("def_mid_cnt", n_mid, 1);
        check("def_bit_cnt", n_bit, 1);

        // 4 + 8/16: intervals alternate 4,5 -> 32 ticks in 144 cycles.
        cycle(1, 1, 1, 4, 8);
        clear_counts();
        run(144);
        check("frac_os_cnt", n_os, 32);

        // Load deferred to the interval boundary.
        cycle(1, 1, 1, 4, 0);
        run(1);
        cycle(1, 0, 1, 10, 0);
        check("defer_pend", div_pending, 1);
        run(30);

        // Rejected load, then a valid one.
        cycle(1, 0, 1, 1, 0);
        check("bad_err", div_err, 1);
        run(12);
        cycle(1, 0, 1, 6, 0);
        check("good_err", div_err, 0);
        run(40);

        // Resync mid-bit after a few ticks.
        cycle(1, 1, 1, 4, 0);
        run(22);
        cycle(1, 1, 0, 0, 0);
        clear_counts();
        run(64);
        check("resync_bit_cnt", n_bit, 1);

        // Asynchronous reset with a load pending.
        cycle(1, 0, 1, 10, 0);
        check("pre_reset_pend", div_pending, 1);
        #3 reset = 1;
        #1;
        check_all_low("async_rst");
        model_reset();
        @(posedge clk);
        #1 reset = 0;
        run(6);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0);
        run(70);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            bit e, r, l;
            e = ($urandom_range(0, 9) != 0);
            r = ($urandom_range(0, 59) == 0);
            l = ($urandom_range(0, 24) == 0);
            cycle(e, r, l, int'($urandom_range(0, 9)), int'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_baud_gen
`default_nettype wire

// File: doc/uart_baud_gen.md
# uart_baud_gen

Programmable fractional baud-rate generator for the UART. It produces a single-cycle oversample tick (`os_tick`) at a runtime-selectable rate, plus `bit_tick` and `mid_tick` pulses derived from it. It sits between the register interface and the UART TX/RX engines. Unlike the fixed divide-by-parameter generator, the divisor has an integer and a fractional part, can be reloaded without glitches, and the phase can be resynchronised for RX start-bit alignment.

## Interface
- `DIV_W`, 16: width of the integer divisor, in clocks per `os_tick`.
- `FRAC_W`, 4: width of the fractional divisor, in 1/2^FRAC_W clock units.
- `OVERSAMPLE`, 16: `os_tick`s per bit. Power of two, at least 4; elaboration fails otherwise.
- `DEF_INT`, 4: integer divisor after reset. At least 2; elaboration fails otherwise.
- `DEF_FRAC`, 0: fractional divisor after reset.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `en` in 1: count enable. When 0, all state is frozen.
- `resync` in 1: single-cycle strobe that restarts the interval and phase.
- `div_int` in DIV_W: new integer divisor.
- `div_frac` in FRAC_W: new fractional divisor.
- `div_load` in 1: single-cycle strobe that requests a load of `div_int`/`div_frac`.
- `div_pending` out 1: a valid load is waiting for the interval boundary.
- `div_err` out 1: sticky flag, set when a load was rejected.
- `os_tick` out 1: oversample tick, one-cycle pulse, registered.
- `mid_tick` out 1: one-cycle pulse on the OVERSAMPLE/2-th `os_tick` of each bit.
- `bit_tick` out 1: one-cycle pulse on the OVERSAMPLE-th `os_tick` of each bit.

## Operation
- Active divisor: `act_int`/`act_frac`. Reset value is `DEF_INT`/`DEF_FRAC`.
- Fractional accumulator `acc` (FRAC_W bits). For each interval:
  - `sum = acc + act_frac` (FRAC_W+1 bits).
  - Interval length `len = act_int + sum[FRAC_W]`.
  - At interval end, `acc <= sum[FRAC_W-1:0]`.
  - Average period is act_int + act_frac/2^FRAC_W clocks.
- Interval counter `cnt` increments on each clock edge with `en=1`. When `cnt == len-1`: `cnt <= 0`, `os_tick <= 1` for one cycle, and `acc` is updated.
- Phase counter `ph` (log2 OVERSAMPLE bits) advances by one on each `os_tick`.
  - `mid_tick` coincides with the `os_tick` that takes `ph` from OVERSAMPLE/2-1 to OVERSAMPLE/2.
  - `bit_tick` coincides with the `os_tick` that wraps `ph` from OVERSAMPLE-1 to 0.
- Divisor load:
  - `div_int < 2` is rejected: `div_err` is set, and active and pending divisors are unchanged.
  - A valid load clears `div_err`.
  - A valid load is applied on the next clock edge if `en=0` or the current cycle is an interval end. Otherwise it is held in a shadow register, `div_pending=1`, and it is applied at the interval end.
  - A later valid load overwrites the shadow (last load wins).
- `resync` (requires `en=1`): `cnt <= 0`, `ph <= 0`, `acc <= 0`. Any pending load is applied and `div_pending` is cleared.
- `en=0`: `cnt`, `ph`, `acc` and `div_pending` hold their values, and the tick outputs are 0.

## Timing
- Reset values: `os_tick`, `mid_tick`, `bit_tick`, `div_pending` and `div_err` are all 0. `cnt`, `ph` and `acc` are 0.
- First `os_tick` is high in the cycle after the len-th `en=1` edge following reset release or `resync`.
- Tick outputs are registered, so there is 1 cycle of latency from the `cnt == len-1` cycle.
- Simultaneous `resync` and valid `div_load`: the new divisor applies and the next interval uses it with `acc=0`.
- Simultaneous interval end and `div_load`: the current `os_tick` is still issued, and the next interval uses the new divisor.
- `resync` on an interval-end cycle: the restart wins and no extra tick is issued after it.
- Reset mid-interval: everything returns to reset values immediately (asynchronous).
- No arithmetic wraps: `len <= 2^DIV_W`, and `cnt` is DIV_W+1 bits wide.

## Structure
- Shared package `uart_pkg` holds:
  - the `OVERSAMPLE` default;
  - the `baud_div_t` struct (`int`, `frac`);
  - the `MIN_DIV_INT = 2` constant.
- Single module. The fractional accumulator and length logic may be factored into `baud_frac_acc`, which is optional; the phase counter stays inline.

## Test plan
- Reset defaults (int 4, frac 0), `en=1`: `os_tick` every 4 cycles; `mid_tick` on the 8th `os_tick`, `bit_tick` on the 16th, then every 64 cycles.
- Load int 4, frac 8 (FRAC_W=4): interval lengths alternate 4, 5, 4, 5; 32 `os_tick`s in 144 cycles.
- `div_load` int 10 on cycle 2 of a 4-cycle interval: `div_pending=1` until that interval's tick; the next interval is 10 cycles; `div_pending` then drops.
- `div_load` int 1: `div_err=1` and the period stays 4; a following load of int 6 clears `div_err`.
- `resync` mid-bit with `ph=5`: next `os_tick` comes `len` edges later; `mid_tick`/`bit_tick` follow on the 8th/16th tick after `resync`.
- Assert `reset` mid-interval with `div_pending=1`: all outputs drop to 0 and the divisor returns to 4/0; `en` low for 20 cycles produces no ticks and the phase resumes unchanged.
